// File: rtl/rv_mem_ctl.sv
// rtl/rv_mem_ctl.sv - single-outstanding memory access controller with stall and sticky error flags.
// Optional access timeout enabled by defining RV_MEM_TIMEOUT_EN.
module rv_mem_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memrw,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        stall,
  output logic [1:0]  err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic [1:0]  err_q, err_d;
  logic        req_in;

`ifdef RV_MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  assign req_in = memrw | rd_en;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    stall   = 1'b0;
`ifdef RV_MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_in) begin
          stall   = 1'b1;
          addr_d  = addr[31:2];
          wdata_d = wdata;
          we_d    = memrw;
          if (addr[1:0] != 2'b00) begin
            err_d[0] = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = REQ;
`ifdef RV_MEM_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_gnt) begin
          state_d = we_q ? DONE : WAIT_R;
`ifdef RV_MEM_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
`ifdef RV_MEM_TIMEOUT_EN
        // The 255th cycle without a grant gives up.
        else if (cnt_q == 8'd254) begin
          err_d[1] = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      WAIT_R: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end
`ifdef RV_MEM_TIMEOUT_EN
        else if (cnt_q == 8'd254) begin
          err_d[1] = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 2'b00;
`ifdef RV_MEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef RV_MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rv_mem_ctl.sv
// tb/tb_rv_mem_ctl.sv - scoreboard bench for rv_mem_ctl; timeout scenario follows RV_MEM_TIMEOUT_EN.
module tb_rv_mem_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        memrw = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rdata;
  logic        stall;
  logic [1:0]  err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  rv_mem_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wdata      (wdata),
    .memrw      (memrw),
    .rd_en      (rd_en),
    .rdata      (rdata),
    .stall      (stall),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          stalls;
    logic [31:0] rdata;
    logic [1:0]  err;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   passes = 0;

  // memory responder configuration, written only by the main process
  int          gd = 0;
  int          rd = 1;
  logic [31:0] rv_data = '0;
  bit          glitch = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: bound expired, stall still high", name);
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] w);
    req_t r;
    r.we = we; r.addr = a; r.wdata = w;
    req_q.push_back(r);
  endtask

  task automatic push_rsp(input int s, input logic [31:0] d, input logic [1:0] e);
    rsp_t r;
    r.stalls = s; r.rdata = d; r.err = e;
    rsp_q.push_back(r);
  endtask

  // Responder: grant after gd waiting cycles, rvalid rd cycles after the grant.
  int req_cnt = 0;
  int rv_cnt = 0;
  bit rv_pending = 1'b0;
  always @(negedge clk) begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (mem_req) begin
      if (req_cnt == gd) begin
        mem_gnt = 1'b1;
        req_cnt = 0;
        if (!mem_we) begin
          rv_pending = 1'b1;
          rv_cnt = 0;
        end
        if (glitch) begin
          mem_rvalid = 1'b1;
          mem_rdata = 32'h0BAD_0BAD;
        end
      end else begin
        req_cnt++;
      end
    end else begin
      req_cnt = 0;
      if (rv_pending) begin
        rv_cnt++;
        if (rv_cnt == rd) begin
          mem_rvalid = 1'b1;
          mem_rdata = rv_data;
          rv_pending = 1'b0;
        end
      end
    end
  end

  // Monitor: checks each granted request and each completed stall window.
  initial begin
    int sc;
    req_t rq;
    rsp_t rs;
    sc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (mem_req && mem_gnt) begin
        if (req_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_mem_req: addr 0x%08h we %0b with nothing expected", mem_addr, mem_we);
        end else begin
          rq = req_q.pop_front();
          check("mem_we", 32'(mem_we), 32'(rq.we));
          check("mem_addr", mem_addr, rq.addr);
          check("mem_wdata", mem_wdata, rq.wdata);
        end
      end
      if (stall) begin
        sc++;
      end else if (sc > 0) begin
        if (rsp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_completion: stalled %0d cycles with nothing expected", sc);
        end else begin
          rs = rsp_q.pop_front();
          check("stall_cycles", 32'(sc), 32'(rs.stalls));
          check("rdata", rdata, rs.rdata);
          check("err", 32'(err), 32'(rs.err));
        end
        sc = 0;
      end
    end
  end

  task automatic access(input logic [31:0] a, input logic [31:0] w, input logic we, input logic re,
                        input int g, input int r, input logic [31:0] d, input bit gl, input int bound);
    int n;
    @(negedge clk);
    gd = g; rd = r; rv_data = d; glitch = gl;
    addr = a; wdata = w; memrw = we; rd_en = re;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (stall && n < bound);
    if (stall) fail_now("access_bound");
    memrw = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    rst = 1'b0;

    push_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    push_rsp(2, 32'h0, 2'b00);
    access(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, 1, 32'h0, 1'b0, 50);

    push_req(1'b0, 32'h0000_0020, 32'h0);
    push_rsp(7, 32'h1234_5678, 2'b00);
    access(32'h0000_0020, 32'h0, 1'b0, 1'b1, 3, 2, 32'h1234_5678, 1'b0, 50);

    // stray rvalid in the grant cycle must be ignored
    push_req(1'b0, 32'h0000_0024, 32'h0);
    push_rsp(3, 32'hCAFE_F00D, 2'b00);
    access(32'h0000_0024, 32'h0, 1'b0, 1'b1, 0, 1, 32'hCAFE_F00D, 1'b1, 50);

    push_rsp(1, 32'hCAFE_F00D, 2'b01);
    access(32'h0000_0003, 32'h0, 1'b0, 1'b1, 0, 1, 32'h0, 1'b0, 50);

    push_req(1'b1, 32'h0000_0040, 32'h55AA_55AA);
    push_rsp(2, 32'hCAFE_F00D, 2'b01);
    access(32'h0000_0040, 32'h55AA_55AA, 1'b1, 1'b1, 0, 1, 32'h0, 1'b0, 50);

    // reset in WAIT_R, then a late rvalid
    @(negedge clk);
    gd = 0; rd = 5; rv_data = 32'hFFFF_FFFF; glitch = 1'b0;
    push_req(1'b0, 32'h0000_0080, 32'h0);
    push_rsp(3, 32'h0, 2'b00);
    addr = 32'h0000_0080; wdata = 32'h0; rd_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("post_rst_rdata", rdata, 32'h0);
    check("post_rst_stall", 32'(stall), 32'h0);
    check("post_rst_mem_req", 32'(mem_req), 32'h0);
    check("post_rst_err", 32'(err), 32'h0);

    push_req(1'b1, 32'h0000_0100, 32'h1122_3344);
    push_rsp(2, 32'h0, 2'b00);
    access(32'h0000_0100, 32'h1122_3344, 1'b1, 1'b0, 0, 1, 32'h0, 1'b0, 50);

`ifdef RV_MEM_TIMEOUT_EN
    push_rsp(256, 32'h0, 2'b10);
    access(32'h0000_0200, 32'h0, 1'b0, 1'b1, 100000, 1, 32'h0, 1'b0, 400);
`else
    @(negedge clk);
    gd = 100000; glitch = 1'b0;
    addr = 32'h0000_0200; wdata = 32'h0; rd_en = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    check("no_timeout_stall", 32'(stall), 32'h1);
    check("no_timeout_mem_req", 32'(mem_req), 32'h1);
    check("no_timeout_err", 32'(err), 32'h0);
`endif

    repeat (3) @(negedge clk);
    check("req_q_drained", 32'(req_q.size()), 32'h0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
